spi_reg_master: RTL and testbench
=================================

// Module: spi_reg_master
// PURPOSE
//  Clock-domain SPI master that issues single-byte register transactions to spi_reg (mode 0, MSB first).
//  Frame: spi_cs low, 16 spi_clk pulses.
//   - Header byte: bit7 = 1 write / 0 read, bits 6:0 = address.
//   - Data byte: write data on spi_mosi, or read data returned on spi_miso.
//  Sits between on-chip control logic (valid/ready command port) and the external SPI pins.
// PARAMETERS
//  CLK_DIV   6   clk cycles per spi_clk half-period; legal range >= 4 (slave synchronises spi_clk)
//  CS_SETUP  12  clk cycles from spi_cs fall to first spi_clk rise minus CLK_DIV (>= 1)
//  CS_HOLD   10  clk cycles from last spi_clk fall to spi_cs rise (>= 1)
//  CS_IDLE   30  minimum clk cycles spi_cs stays high between frames (>= 1)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_write  in   1  1 = write, 0 = read
//  cmd_addr   in   7  register address
//  cmd_wdata  in   8  write data (ignored for reads)
//  rsp_valid  out  1  one-cycle pulse when a frame completes
//  rsp_rdata  out  8  read byte (valid with rsp_valid; 8'h00 after writes)
//  busy       out  1  high from acceptance until end of CS_IDLE gap
//  spi_clk    out  1  SPI clock, idle low
//  spi_cs     out  1  chip select, active low
//  spi_mosi   out  1  master out
//  spi_miso   in   1  slave out (may be X/Z while spi_cs high)
// BEHAVIOUR
//  Reset (async, immediate):
//   - spi_cs=1, spi_clk=0, spi_mosi=0.
//   - cmd_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, FSM=IDLE.
//  Acceptance at cycle T:
//   - {cmd_write,cmd_addr,cmd_wdata} latched into 16-bit shift reg.
//   - Command inputs ignored thereafter.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; all outputs registered.
//  SETUP: entered T+1.
//   - spi_cs=0 and spi_mosi=shift[15] from T+1.
//   - Lasts CS_SETUP cycles.
//  SHIFT: 16 bits, bit k = 0..15, each 2*CLK_DIV cycles.
//   - Low phase: CLK_DIV cycles, spi_clk=0; spi_mosi updated to bit k at start of low phase (bit 0 already set in SETUP).
//   - High phase: CLK_DIV cycles, spi_clk=1; spi_mosi stable.
//   - Bits 8..15 of a read: spi_miso sampled in the last clk cycle of each high phase, shifted MSB-first into rdata.
//   - Writes: spi_miso is never sampled.
//   - spi_mosi after bit 15: held at last bit until HOLD ends.
//  HOLD: spi_clk=0 for CS_HOLD cycles, then spi_cs=1 and spi_mosi=0 in the same cycle.
//  rsp_valid: pulses exactly in the first cycle spi_cs is high again.
//   - rsp_rdata = sampled byte (read) or 8'h00 (write).
//   - rsp_rdata holds until the next rsp_valid.
//  GAP: CS_IDLE cycles with spi_cs=1, then IDLE with cmd_ready=1.
//  Timing at defaults:
//   - spi_cs low = CS_SETUP + 32*CLK_DIV + CS_HOLD = 214 cycles.
//   - Accept-to-rsp_valid = 215 cycles.
//   - Accept-to-next-ready = 245 cycles.
//  Exactly 16 spi_clk rising edges per frame; spi_clk never toggles while spi_cs=1.
//  Boundaries:
//   - cmd_valid held during busy: no acceptance, no queuing.
//   - cmd_valid in the same cycle GAP ends: not accepted until cmd_ready is visible (registered ready).
//   - Address 7'h7F and data 8'hFF/8'h00: no special casing.
//   - X on spi_miso outside sampling cycles: must not propagate to rsp_rdata.
//   - Reset mid-frame: frame aborted, no rsp_valid, spi_cs high immediately.
//  Counters sized by $clog2 of parameters; no wrap within legal parameter ranges.
// TESTING
//  T1:
//   - Stimulus: write addr 7'h05, data 8'hA5.
//   - Response: mosi at rising edges = 1,0000101,10100101; 16 rises; spi_cs low 214 cycles; rsp_valid once with rdata 8'h00.
//  T2:
//   - Stimulus: read addr 7'h2A; behavioural mode-0 slave (miso updated on falling edge) returns 8'h3C.
//   - Response: header mosi = 0,0101010; rsp_rdata = 8'h3C at rsp_valid.
//  T3:
//   - Stimulus: cmd_valid held high with 3 queued commands.
//   - Response: exactly 3 frames; spi_cs high >= 30 cycles between frames; cmd_ready low throughout busy.
//  T4:
//   - Stimulus: rst_n low during bit 9 of a read.
//   - Response: spi_cs=1, spi_clk=0, spi_mosi=0 same cycle; no rsp_valid; next command completes normally.
//  T5:
//   - Stimulus: integration with spi_reg; write i->addr i for i=0..15, then read addr 0..15.
//   - Response: each rsp_rdata == i.
//  T6:
//   - Stimulus: CLK_DIV=4, CS_SETUP=1, CS_HOLD=1, CS_IDLE=1; read 7'h7F with slave returning 8'hFF.
//   - Response: rdata 8'hFF; spi_cs low 130 cycles.

Source files
------------

// File: rtl/spi_reg_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_master_if
// Brief    : Command/response port bundle between on-chip control logic and
//            the SPI register master. The controller drives commands through
//            the master modport; spi_reg_master implements the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_reg_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;

    // Controller side: issues commands, observes responses
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    // SPI master side: accepts commands, produces responses
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_master
// Brief    : SPI mode-0 master issuing single-byte register transactions.
//            Frame = 8-bit header {rw, addr[6:0]} followed by one data byte,
//            MSB first, framed by an active-low chip select.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_master #(
    parameter int CLK_DIV  = 6,   // clk cycles per spi_clk half-period
    parameter int CS_SETUP = 12,  // extra cs-to-first-edge setup cycles
    parameter int CS_HOLD  = 10,  // last falling edge to cs release
    parameter int CS_IDLE  = 30   // minimum cs-high gap between frames
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_reg_master_if.slave bus,
    output logic            spi_clk,
    output logic            spi_cs,
    output logic            spi_mosi,
    input  logic            spi_miso
);

    // One down-counter serves every timed phase, so size it for the largest
    localparam int c_max_a   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int c_max_b   = (CS_HOLD > CS_IDLE)  ? CS_HOLD : CS_IDLE;
    localparam int c_cnt_max = (c_max_a > c_max_b)  ? c_max_a : c_max_b;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_div_ld   = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(CS_SETUP - 1);
    localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(CS_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_idle_ld  = c_cnt_w'(CS_IDLE - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_hold  = 3'd3;
    localparam logic [2:0] c_st_gap   = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_bit;       // index of the bit currently on the wire
    logic [14:0]        r_shift;     // bits still to be sent after the current one
    logic [7:0]         r_rd_sh;     // read data collected from spi_miso
    logic               r_write;
    logic               r_ready;
    logic               r_busy;
    logic               r_rsp_valid;
    logic [7:0]         r_rsp_rdata;

    logic               w_cnt_zero;
    logic               w_sample;

    assign w_cnt_zero = (r_cnt == '0);
    // Only the data byte of a read is taken from spi_miso; X elsewhere is ignored
    assign w_sample   = r_bit[3] & ~r_write;

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

    // Frame sequencer: every output is a register updated from the current phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit       <= 4'd0;
            r_shift     <= 15'd0;
            r_rd_sh     <= 8'h00;
            r_write     <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            spi_clk     <= 1'b0;
            spi_cs      <= 1'b1;
            spi_mosi    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // Ready is registered, so acceptance needs it already visible
                    if (bus.cmd_valid && r_ready) begin
                        r_state  <= c_st_setup;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_write  <= bus.cmd_write;
                        r_shift  <= {bus.cmd_addr, bus.cmd_wdata};
                        r_bit    <= 4'd0;
                        r_cnt    <= c_setup_ld;
                        spi_cs   <= 1'b0;
                        spi_mosi <= bus.cmd_write;
                    end
                end

                c_st_setup: begin
                    // Bit 0 is already on mosi; its low phase follows directly
                    if (w_cnt_zero) begin
                        r_state <= c_st_shift;
                        r_cnt   <= c_div_ld;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                c_st_shift: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else if (!spi_clk) begin
                        // End of low phase: raise spi_clk
                        spi_clk <= 1'b1;
                        r_cnt   <= c_div_ld;
                    end else begin
                        // Last cycle of high phase: sample, then fall
                        if (w_sample) begin
                            r_rd_sh <= {r_rd_sh[6:0], spi_miso};
                        end
                        spi_clk <= 1'b0;
                        if (r_bit == 4'd15) begin
                            r_state <= c_st_hold;
                            r_cnt   <= c_hold_ld;
                        end else begin
                            r_bit    <= r_bit + 4'd1;
                            spi_mosi <= r_shift[14];
                            r_shift  <= {r_shift[13:0], 1'b0};
                            r_cnt    <= c_div_ld;
                        end
                    end
                end

                c_st_hold: begin
                    // Release cs and report the result in the same edge
                    if (w_cnt_zero) begin
                        r_state     <= c_st_gap;
                        r_cnt       <= c_idle_ld;
                        spi_cs      <= 1'b1;
                        spi_mosi    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_write ? 8'h00 : r_rd_sh;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                c_st_gap: begin
                    if (w_cnt_zero) begin
                        r_state <= c_st_idle;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                default: begin
                    r_state  <= c_st_idle;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    spi_clk  <= 1'b0;
                    spi_cs   <= 1'b1;
                    spi_mosi <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_master
// Brief    : Scoreboard bench for spi_reg_master with a behavioural mode-0
//            register slave and a small-parameter second instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_master;

    localparam int c_cs_low  = 214;
    localparam int c_rsp_lat = 215;
    localparam int c_rdy_lat = 245;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- main DUT (default parameters) ----------------
    spi_reg_master_if bus ();
    logic sclk, cs, mosi, miso;

    spi_reg_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .spi_clk  (sclk),
        .spi_cs   (cs),
        .spi_mosi (mosi),
        .spi_miso (miso)
    );

    // ---------------- small DUT (minimum timing) ----------------
    spi_reg_master_if bus_s ();
    logic sclk_s, cs_s, mosi_s, miso_s;

    spi_reg_master #(.CLK_DIV(4), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_s),
        .spi_clk  (sclk_s),
        .spi_cs   (cs_s),
        .spi_mosi (mosi_s),
        .spi_miso (miso_s)
    );

    // ---------------- behavioural register slave (main) ----------------
    logic [7:0]  sl_mem [128];
    logic [7:0]  sl_hdr;
    logic [15:0] sl_sh;
    int          sl_n = 0;
    initial miso = 1'bx;

    always @(negedge cs) sl_n = 0;
    always @(posedge cs) miso = 1'bx;
    always @(posedge sclk) if (!cs) begin
        sl_sh = {sl_sh[14:0], mosi};
        sl_n++;
        if (sl_n == 8) sl_hdr = sl_sh[7:0];
        if (sl_n == 16 && sl_hdr[7]) sl_mem[sl_hdr[6:0]] = sl_sh[7:0];
    end
    always @(negedge sclk) if (!cs && sl_n >= 8 && sl_n < 16 && !sl_hdr[7])
        miso = sl_mem[sl_hdr[6:0]][15 - sl_n];

    // ---------------- byte-source slave (small DUT) ----------------
    logic [7:0] s_byte = 8'h00;
    int         s_n = 0;
    initial miso_s = 1'bx;
    always @(negedge cs_s) s_n = 0;
    always @(posedge cs_s) miso_s = 1'bx;
    always @(posedge sclk_s) if (!cs_s) s_n++;
    always @(negedge sclk_s) if (!cs_s && s_n >= 8 && s_n < 16) miso_s = s_byte[15 - s_n];

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
        int          acc;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] ref_mem [128];
    int         last_acc = 0;
    bit         have_last = 0;

    // Monitor: frame shape, timing and response checks, sampled on falling clk
    int          m_low, m_rises, m_high;
    logic [15:0] m_frame;
    logic        m_pcs, m_psclk;
    bit          m_seen;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_low = 0; m_rises = 0; m_high = 0; m_frame = 16'h0;
            m_pcs = 1'b1; m_psclk = 1'b0; m_seen = 0;
        end else begin
            if (cs) begin
                chk("sclk_idle_when_cs_high", {31'd0, sclk}, 32'd0);
                if (!m_pcs) begin
                    chk("rsp_valid_at_cs_rise", {31'd0, bus.rsp_valid}, 32'd1);
                    chk("rises_per_frame", m_rises, 16);
                    chk("cs_low_cycles", m_low, c_cs_low);
                    if (exp_q.size() > 0) chk("mosi_frame", {16'd0, m_frame}, {16'd0, exp_q[0].frame});
                    m_high = 0;
                    m_seen = 1;
                end
                m_high++;
            end else begin
                if (m_pcs) begin
                    if (m_seen) chk("cs_gap_ge_30", {31'd0, m_high >= 30}, 32'd1);
                    m_low = 0; m_rises = 0;
                end
                m_low++;
                if (sclk && !m_psclk) begin
                    m_frame = {m_frame[14:0], mosi};
                    m_rises++;
                end
            end
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%0h expected no response (cycle %0d)", bus.rsp_rdata, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e.rdata});
                    chk("accept_to_rsp", cyc - e.acc, c_rsp_lat);
                end
            end
            if (bus.busy) chk("ready_low_in_busy", {31'd0, bus.cmd_ready}, 32'd0);
            m_pcs  = cs;
            m_psclk = sclk;
        end
    end

    // Issue one command; hold keeps cmd_valid asserted afterwards
    task automatic do_cmd(input logic w, input logic [6:0] a, input logic [7:0] d, input bit hold);
        int  n;
        bit  waited;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        waited = !bus.cmd_ready;
        n = 0;
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: got cmd_ready=0 for %0d cycles expected 1", n);
            bus.cmd_valid = 1'b0;
            return;
        end
        if (waited && have_last) chk("accept_to_next_ready", cyc - last_acc, c_rdy_lat);
        e.frame = {w, a, d};
        e.rdata = w ? 8'h00 : ref_mem[a];
        e.acc   = cyc;
        if (w) ref_mem[a] = d;
        exp_q.push_back(e);
        last_acc  = cyc;
        have_last = 1;
        @(negedge clk);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Small-instance transaction with its own inline frame observer
    task automatic s_cmd(input logic w, input logic [6:0] a, input logic [7:0] d, input logic [7:0] sb);
        int n, low, rises;
        logic [15:0] fr;
        logic ps;
        s_byte = sb;
        @(negedge clk);
        bus_s.cmd_valid = 1'b1;
        bus_s.cmd_write = w;
        bus_s.cmd_addr  = a;
        bus_s.cmd_wdata = d;
        n = 0;
        while (!bus_s.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus_s.cmd_valid = 1'b0;
        low = 0; rises = 0; fr = 16'h0; ps = 1'b0;
        while (!cs_s && low < 1000) begin
            low++;
            if (sclk_s && !ps) begin
                fr = {fr[14:0], mosi_s};
                rises++;
            end
            ps = sclk_s;
            @(negedge clk);
        end
        chk("small_cs_low", low, 130);
        chk("small_rises", rises, 16);
        chk("small_frame", {16'd0, fr}, {16'd0, w, a, d});
        chk("small_rsp_valid", {31'd0, bus_s.rsp_valid}, 32'd1);
        chk("small_rdata", {24'd0, bus_s.rsp_rdata}, {24'd0, (w ? 8'h00 : sb)});
        repeat (5) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [7:0] v;
        bus.cmd_valid   = 1'b0; bus.cmd_write   = 1'b0; bus.cmd_addr   = 7'h0; bus.cmd_wdata   = 8'h0;
        bus_s.cmd_valid = 1'b0; bus_s.cmd_write = 1'b0; bus_s.cmd_addr = 7'h0; bus_s.cmd_wdata = 8'h0;
        for (int i = 0; i < 128; i++) begin
            v = 8'($urandom);
            sl_mem[i]  = v;
            ref_mem[i] = v;
        end

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", {31'd0, cs}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1 write, T2 read with known slave contents
        do_cmd(1'b1, 7'h05, 8'hA5, 0);
        drain();
        sl_mem[7'h2A]  = 8'h3C;
        ref_mem[7'h2A] = 8'h3C;
        do_cmd(1'b0, 7'h2A, 8'h00, 0);
        drain();

        // T3 cmd_valid held across three back-to-back commands
        do_cmd(1'b1, 7'h7F, 8'hFF, 1);
        do_cmd(1'b1, 7'h00, 8'h00, 1);
        do_cmd(1'b0, 7'h7F, 8'h5A, 1);
        bus.cmd_valid = 1'b0;
        drain();

        // T4 reset during bit 9 of a read
        have_last = 0;
        do_cmd(1'b0, 7'h11, 8'h00, 0);
        n = 0;
        while (m_rises < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_bit9", {31'd0, m_rises >= 10}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", {31'd0, cs}, 32'd1);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        chk("abort_mosi", {31'd0, mosi}, 32'd0);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
        exp_q.delete();
        have_last = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        do_cmd(1'b0, 7'h11, 8'h00, 0);
        drain();

        // T5 register round trip through the slave
        for (int i = 0; i < 16; i++) do_cmd(1'b1, 7'(i), 8'(i), 0);
        for (int i = 0; i < 16; i++) do_cmd(1'b0, 7'(i), 8'h00, 0);
        drain();

        // Randomised traffic with random gaps and held valid
        for (int k = 0; k < 20; k++) begin
            do_cmd(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                bus.cmd_valid = 1'b0;
                repeat ($urandom_range(0, 300)) @(negedge clk);
            end
        end
        bus.cmd_valid = 1'b0;
        drain();

        // T6 minimum-timing instance
        s_cmd(1'b0, 7'h7F, 8'h00, 8'hFF);
        s_cmd(1'b1, 7'h33, 8'hC3, 8'hFF);
        s_cmd(1'b0, 7'($urandom), 8'h00, 8'($urandom));

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
